// File: rtl/cnt_nested_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the nested loop counter:
//   cnt_state_e : sequencing states (idle / running)
//   MAX_LEV     : largest supported number of nesting levels
//   MAX_W       : widest value the sanitize helper handles
//   sanitize()  : maps a zero limit/step onto 1 so every level makes progress
// ---------------------------------------------------------------------------
package cnt_pkg;

   typedef enum logic {
      CNT_IDLE = 1'b0,
      CNT_RUN  = 1'b1
   } cnt_state_e;

   localparam int MAX_LEV = 8;
   localparam int MAX_W   = 32;

   // A zero limit would never let the level wrap; a zero step would never
   // let it move. Both are replaced by 1.
   function automatic logic [MAX_W-1:0] sanitize(input logic [MAX_W-1:0] value);
      return (value == '0) ? MAX_W'(1) : value;
   endfunction

endpackage

// File: rtl/cnt_nested_if.sv
// ---------------------------------------------------------------------------
// cnt_nested_if
// Configuration / control / status bundle of the nested loop counter.
//   i_lim, i_step : packed per-level limit and step, level k at [k*CNT_W +: CNT_W]
//   i_start       : start pulse
//   i_en          : advance request (one pulse = one innermost iteration)
//   i_clear       : synchronous abort and clear
//   o_busy        : running
//   o_done        : one-cycle pulse after the final advance
//   o_flags       : per-level wrap indication for the current advance
//   o_last        : current tuple is the final iteration
//   o_cnt         : packed counter values
// Modports: master drives the controls (feeder / bench), slave is the counter.
// ---------------------------------------------------------------------------
interface cnt_nested_if #(
   parameter int CNT_W = 8,
   parameter int N_LEV = 3
);

   logic [N_LEV*CNT_W-1:0] i_lim;
   logic [N_LEV*CNT_W-1:0] i_step;
   logic                   i_start;
   logic                   i_en;
   logic                   i_clear;
   logic                   o_busy;
   logic                   o_done;
   logic [N_LEV-1:0]       o_flags;
   logic                   o_last;
   logic [N_LEV*CNT_W-1:0] o_cnt;

   modport master (
      output i_lim, i_step, i_start, i_en, i_clear,
      input  o_busy, o_done, o_flags, o_last, o_cnt
   );

   modport slave (
      input  i_lim, i_step, i_start, i_en, i_clear,
      output o_busy, o_done, o_flags, o_last, o_cnt
   );

endinterface

// File: rtl/cnt_nested_level.sv
// ---------------------------------------------------------------------------
// cnt_nested_level
// One level of the nested counter: latched (sanitised) limit and step, the
// counter register, and the wrap / carry logic of the carry chain.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   load          : latch lim_in/step_in (accepted start)
//   zero          : force counter to 0 (start or clear)
//   carry_in      : this level advances this cycle
//   lim_in,step_in: configuration to latch
//   cnt           : registered counter value
//   wrap          : cnt + step would reach or pass the limit
//   carry_out     : carry_in && wrap, advances the next outer level
// ---------------------------------------------------------------------------
module cnt_nested_level
   import cnt_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             load,
   input  logic             zero,
   input  logic             carry_in,
   input  logic [CNT_W-1:0] lim_in,
   input  logic [CNT_W-1:0] step_in,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             carry_out
);

   logic [CNT_W-1:0] lim_q;
   logic [CNT_W-1:0] step_q;
   logic [CNT_W:0]   sum;

   // One extra bit so a large step near the top of the range cannot alias
   // back below the limit.
   assign sum       = {1'b0, cnt} + {1'b0, step_q};
   assign wrap      = (sum >= {1'b0, lim_q});
   assign carry_out = carry_in && wrap;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         lim_q  <= '0;
         step_q <= '0;
         cnt    <= '0;
      end else begin
         if (load) begin
            lim_q  <= CNT_W'(sanitize(MAX_W'(lim_in)));
            step_q <= CNT_W'(sanitize(MAX_W'(step_in)));
         end
         if (zero) begin
            cnt <= '0;
         end else if (carry_in) begin
            cnt <= wrap ? '0 : sum[CNT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cnt_nested.sv
// ---------------------------------------------------------------------------
// cnt_nested
// Parametrised N_LEV-level nested loop counter (level 0 innermost) with
// start/busy/done sequencing. One effective i_en advances the innermost
// level; outer levels advance only when every inner level wraps.
//   i_clk  : clock, rising edge
//   i_rstn : asynchronous active-low reset
//   bus    : cnt_nested_if.slave (configuration, controls, status, counts)
// ---------------------------------------------------------------------------
module cnt_nested
   import cnt_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int N_LEV = 3
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   cnt_nested_if.slave  bus
);

   cnt_state_e             state;
   logic                   busy_q;
   logic                   done_q;
   logic                   run;
   logic                   adv;
   logic                   last;
   logic                   fin;
   logic                   start_acc;
   logic                   zero;
   logic [N_LEV:0]         carry;
   logic [N_LEV-1:0]       wrap;
   logic [N_LEV*CNT_W-1:0] cnt;

   assign run       = (state == CNT_RUN);
   assign adv       = run && bus.i_en && !bus.i_clear;
   assign last      = run && (&wrap);
   assign fin       = adv && last;
   assign start_acc = !run && bus.i_start && !bus.i_clear;
   // The final advance needs no explicit zeroing: every level wraps to 0.
   assign zero      = bus.i_clear || start_acc;
   assign carry[0]  = adv;

   for (genvar k = 0; k < N_LEV; k++) begin : g_lev
      cnt_nested_level #(
         .CNT_W (CNT_W)
      ) u_lev (
         .i_clk     (i_clk),
         .i_rstn    (i_rstn),
         .load      (start_acc),
         .zero      (zero),
         .carry_in  (carry[k]),
         .lim_in    (bus.i_lim[k*CNT_W +: CNT_W]),
         .step_in   (bus.i_step[k*CNT_W +: CNT_W]),
         .cnt       (cnt[k*CNT_W +: CNT_W]),
         .wrap      (wrap[k]),
         .carry_out (carry[k+1])
      );
   end

   // Sequencing: clear dominates, then start (idle) or final advance (run).
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state  <= CNT_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= fin;
         if (bus.i_clear) begin
            state  <= CNT_IDLE;
            busy_q <= 1'b0;
         end else begin
            case (state)
               CNT_IDLE: begin
                  if (bus.i_start) begin
                     state  <= CNT_RUN;
                     busy_q <= 1'b1;
                  end
               end
               CNT_RUN: begin
                  if (fin) begin
                     state  <= CNT_IDLE;
                     busy_q <= 1'b0;
                  end
               end
               default: begin
                  state  <= CNT_IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // carry[k+1] is exactly carry_k && wrap_k.
   assign bus.o_flags = carry[N_LEV:1];
   assign bus.o_last  = last;
   assign bus.o_cnt   = cnt;
   assign bus.o_busy  = busy_q;
   assign bus.o_done  = done_q;

endmodule

// File: tb/tb_cnt_nested.sv
// ---------------------------------------------------------------------------
// tb_cnt_nested
// Scoreboard bench for cnt_nested. The reference model treats a run as a
// mixed-radix count: level k has ceil(lim_k/step_k) values, the current
// tuple is an index into their Cartesian product, and wraps/last follow from
// the digits of that index.
// ---------------------------------------------------------------------------
module tb_cnt_nested;

   localparam int W = 8;
   localparam int N = 3;

   typedef struct {
      logic         busy;
      logic         done;
      logic         last;
      logic [N-1:0] flags;
      logic [N*W-1:0] cnt;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   cnt_nested_if #(.CNT_W(W), .N_LEV(N)) bus ();

   cnt_nested #(.CNT_W(W), .N_LEV(N)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   obs_done = 0;
   int   exp_done = 0;

   // reference model state
   bit   m_run  = 0;
   bit   m_done = 0;
   int   m_idx  = 0;
   int   m_total = 1;
   int   m_step[N];
   int   m_n[N];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic int digit(input int k, input int idx);
      int div = 1;
      for (int j = 0; j < k; j++) div = div * m_n[j];
      return (idx / div) % m_n[k];
   endfunction

   function automatic logic [N*W-1:0] tuple_of(input int idx);
      logic [N*W-1:0] v = '0;
      for (int k = 0; k < N; k++) v[k*W +: W] = W'(digit(k, idx) * m_step[k]);
      return v;
   endfunction

   function automatic logic [N*W-1:0] pack3(input int a2, input int a1, input int a0);
      return {W'(a2), W'(a1), W'(a0)};
   endfunction

   task automatic model_latch(input logic [N*W-1:0] lim, input logic [N*W-1:0] step);
      int l, s;
      m_total = 1;
      for (int k = 0; k < N; k++) begin
         l = int'(lim[k*W +: W]);
         s = int'(step[k*W +: W]);
         if (l == 0) l = 1;
         if (s == 0) s = 1;
         m_step[k] = s;
         m_n[k]    = (l + s - 1) / s;
         m_total   = m_total * m_n[k];
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_done = 0; m_idx = 0;
   endtask

   // Drive one cycle of stimulus, queue the expected observation, step model.
   task automatic cycle(input bit st, input bit en, input bit clr,
                        input logic [N*W-1:0] lim, input logic [N*W-1:0] step);
      exp_t e;
      bit   adv, lastv, all;
      @(posedge clk);
      #1;
      bus.i_start = st;
      bus.i_en    = en;
      bus.i_clear = clr;
      bus.i_lim   = lim;
      bus.i_step  = step;
      adv    = m_run && en && !clr;
      lastv  = m_run && (m_idx == m_total - 1);
      e.busy = m_run;
      e.done = m_done;
      e.cnt  = m_run ? tuple_of(m_idx) : '0;
      e.last = lastv;
      for (int k = 0; k < N; k++) begin
         all = 1;
         for (int j = 0; j <= k; j++) if (digit(j, m_idx) != m_n[j] - 1) all = 0;
         e.flags[k] = adv && all;
      end
      sb.push_back(e);
      m_done = adv && lastv;
      if (m_done) exp_done++;
      if (clr) begin
         m_run = 0; m_idx = 0;
      end else if (m_run) begin
         if (adv) begin
            if (lastv) begin m_run = 0; m_idx = 0; end
            else m_idx++;
         end
      end else if (st) begin
         model_latch(lim, step);
         m_run = 1; m_idx = 0;
      end
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && bus.o_done === 1'b1) obs_done++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("busy",  64'(bus.o_busy),  64'(e.busy));
            chk("done",  64'(bus.o_done),  64'(e.done));
            chk("last",  64'(bus.o_last),  64'(e.last));
            chk("flags", 64'(bus.o_flags), 64'(e.flags));
            chk("cnt",   64'(bus.o_cnt),   64'(e.cnt));
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  64'(bus.o_busy),  64'(0));
      chk({tag, "_done"},  64'(bus.o_done),  64'(0));
      chk({tag, "_last"},  64'(bus.o_last),  64'(0));
      chk({tag, "_flags"}, 64'(bus.o_flags), 64'(0));
      chk({tag, "_cnt"},   64'(bus.o_cnt),   64'(0));
   endtask

   initial begin
      logic [N*W-1:0] lim, step, rl, rs;
      int guard;
      bus.i_start = 0; bus.i_en = 0; bus.i_clear = 0;
      bus.i_lim = '0; bus.i_step = '0;
      for (int k = 0; k < N; k++) begin m_step[k] = 1; m_n[k] = 1; end
      fork
         monitor_loop();
      join_none

      #2;
      chk_all_zero("reset");
      #20;
      rstn = 1;
      model_reset();

      // idle: en ignored, flags stay 0
      lim = pack3(2, 3, 4); step = pack3(1, 1, 1);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, lim, step);

      // full sweep of 24 tuples
      cycle(1, 0, 0, lim, step);
      for (int i = 0; i < 24; i++) cycle(0, 1, 0, lim, step);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, lim, step);

      // overflow-safe arithmetic on level 0
      lim = pack3(1, 1, 255); step = pack3(1, 1, 200);
      cycle(1, 0, 0, lim, step);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, lim, step);

      // degenerate level 1 (lim 0, step 0); done-cycle start back to back
      lim = pack3(2, 0, 3); step = pack3(1, 0, 1);
      cycle(1, 0, 0, lim, step);
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, lim, step);
      cycle(1, 0, 0, lim, step);
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, lim, step);

      // clear with start at tuple (0,1,2), then a full run
      lim = pack3(2, 3, 4); step = pack3(1, 1, 1);
      cycle(1, 0, 0, lim, step);
      guard = 0;
      while (m_idx != 6 && guard < 50) begin cycle(0, 1, 0, lim, step); guard++; end
      chk("clear_reach", 64'(m_idx), 64'(6));
      cycle(1, 1, 1, lim, step);
      cycle(0, 1, 0, lim, step);
      cycle(1, 0, 0, lim, step);
      for (int i = 0; i < 26; i++) cycle(0, 1, 0, lim, step);

      // random en/start/config churn with rare clears
      for (int i = 0; i < 800; i++) begin
         for (int k = 0; k < N; k++) begin
            rl[k*W +: W] = W'($urandom_range(0, 5));
            rs[k*W +: W] = W'($urandom_range(0, 3));
         end
         cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
               ($urandom_range(0, 99) == 0), rl, rs);
      end

      // async reset in the middle of a run
      lim = pack3(3, 3, 3); step = pack3(1, 1, 1);
      cycle(1, 0, 0, lim, step);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, lim, step);
      @(negedge clk);
      #2;
      chk("pre_reset_busy", 64'(bus.o_busy), 64'(1));
      rstn = 0;
      #1;
      chk_all_zero("async");
      model_reset();
      @(posedge clk);
      #1;
      chk_all_zero("inreset");
      bus.i_en = 0; bus.i_start = 0;
      #2;
      rstn = 1;
      lim = pack3(1, 2, 2); step = pack3(1, 1, 1);
      cycle(1, 0, 0, lim, step);
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, lim, step);

      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'(0));
      chk("done_count", 64'(obs_done), 64'(exp_done));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cnt_nested.md
Name: cnt_nested

Overview:
- Parametrised N-level nested loop counter, the successor to the single-level generic counter.
- Each level has its own limit and step. Level 0 is innermost; a higher level advances only when all lower levels wrap (carry chain).
- Adds start/busy/done sequencing, latched configuration and overflow-safe arithmetic.
- Drives the address generators and loop control of the dataflow feeders: one `i_en` pulse equals one innermost iteration.

Parameters:
- CNT_W, 8: width of every counter value, limit and step.
- N_LEV, 3: number of nested levels (1..8).

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_lim  in  N_LEV*CNT_W  per-level limit (exclusive), packed, level k at bits [k*CNT_W +: CNT_W]; sampled on accepted start
- i_step  in  N_LEV*CNT_W  per-level step, same packing; sampled on accepted start
- i_start  in  1  start pulse; accepted only in IDLE
- i_en  in  1  advance request; effective only in RUN
- i_clear  in  1  synchronous abort and clear; highest priority
- o_busy  out  1  high while in RUN
- o_done  out  1  one-cycle pulse, the cycle after the final advance
- o_flags  out  N_LEV  combinational per-level wrap indication for the current effective advance
- o_last  out  1  combinational; current counter tuple is the final iteration
- o_cnt  out  N_LEV*CNT_W  registered counter values, same packing as i_lim

Behaviour:
- Reset (i_rstn low, async):
  - State IDLE, all counters 0, latched lim/step 0.
  - o_busy=0, o_done=0, o_flags=0, o_last=0.
- States are IDLE and RUN.
- IDLE → RUN on i_start && !i_clear:
  - Latch i_lim and i_step into internal registers.
  - Counters go to 0.
  - o_busy=1 from the next cycle.
- Configuration sanitising at latch time: per level, lim==0 is stored as 1; step==0 is stored as 1.
- Effective advance: adv = RUN && i_en && !i_clear.
- Per-level arithmetic:
  - sum_k = cnt_k + step_k, computed at CNT_W+1 bits so there is no truncation.
  - wrap_k = (sum_k >= lim_k).
- Carry chain:
  - carry_0 = adv; carry_{k+1} = carry_k && wrap_k.
  - When carry_k is set, level k loads 0 if wrap_k, otherwise sum_k[CNT_W-1:0]. When carry_k is clear, level k holds.
- o_flags[k] = carry_k && wrap_k.
- o_last = RUN && AND over all k of wrap_k. It is independent of i_en, so it can be used for lookahead.
- Final advance (adv && o_last):
  - All counters go to 0.
  - Next state IDLE; o_busy=0 and o_done=1 on the next cycle.
  - o_done is a one-cycle pulse.
- i_clear (any state): next cycle is IDLE with counters 0. No o_done is generated, and an o_done pending from the previous cycle is not suppressed. Latched configuration is kept.
- i_start while RUN is ignored; the configuration is not relatched.
- i_start together with i_clear: clear wins and the block stays IDLE.
- i_start in the same cycle o_done is high: accepted normally, giving back-to-back runs with no dead cycle beyond the done cycle.
- i_en while IDLE is ignored; o_flags=0.
- Latched limits are not re-sampled mid-run; changes on i_lim/i_step during RUN have no effect.
- Latency: o_cnt updates the cycle after an effective advance. Total run length is the product over k of ceil(lim_k/step_k) advances.
- Reset mid-run aborts immediately to the reset state.

Decomposition:
- Package cnt_pkg:
  - cnt_state_e enum {CNT_IDLE, CNT_RUN}.
  - Constant MAX_LEV=8.
  - Helper function sanitize(value) returning 1 when value==0.
- Sub-module cnt_nested_level: one level with latched lim/step, carry-in, wrap and carry-out logic.
  - Generated N_LEV times.
  - The top owns the FSM, the done pulse and the packing.

Test Plan:
- N_LEV=3, CNT_W=8, lim={2,3,4} (L2,L1,L0), step all 1, start then i_en held high → o_cnt sweeps 24 tuples in lexicographic order. o_flags[0] on every 4th advance, o_flags[1] every 12th. o_last at tuple (1,2,3). o_done exactly 1 cycle after the 24th advance. o_busy low afterwards.
- Overflow-safe arithmetic: CNT_W=8, level 0 lim=255, step=200 → sequence 0, 200, wrap (sum 400 ≥ 255, no truncation to 144). o_flags[0] on the 2nd advance.
- Degenerate configuration: lim=0 and step=0 on level 1 → level 1 is treated as lim 1; every level-0 wrap propagates to level 2. Run length equals lim0*lim2.
- Clear mid-run at tuple (0,1,2), with i_start asserted in the same cycle → next cycle IDLE, counters 0, o_busy=0, no o_done. A subsequent start runs a full sequence.
- i_en toggling randomly, plus i_start pulses and i_lim changes during RUN → counters advance only on i_en cycles. The configuration latched at start is preserved. Total advances equal the product of the latched limits.
- Async reset asserted mid-cycle during RUN → all outputs 0 immediately, independent of the clock. Start after release works normally.
